axi_txn_scheduler: RTL and testbench
====================================

Name: axi_txn_scheduler

Overview:
- Sequences the AXI4-Lite master's instruction interface (mode, addra/addrb, txn_en, inst_done) on behalf of two requesters: port 0 = activation/weight loader, port 1 = result writer.
- Accepts block commands of the form {mode, base address, transaction count}.
- Arbitrates round-robin between the two requesters.
- Expands each command into per-instruction txn_en handshakes with an auto-incremented address, and reports completion or error per command.

Parameters:
- ADDR_WIDTH, 32, AXI address width
- CNT_WIDTH, 8, width of transaction count
- ADDR_STEP, 4, address increment per instruction (matches AXI_TRANSACTIONS_NUM = 4)
- TIMEOUT_CYCLES, 1024, max cycles waiting on any inst_done edge before error

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req0_valid  in  1  command valid, requester 0
- req0_ready  out  1  command accepted, requester 0
- req0_mode  in  2  0 IDLE, 1 LOAD_DATA, 2 WRITE_DATA, 3 reserved
- req0_addr  in  ADDR_WIDTH  base address
- req0_count  in  CNT_WIDTH  number of instructions
- req0_done  out  1  one-cycle completion pulse
- req0_err  out  1  valid with req0_done; 1 = illegal mode or timeout
- req1_valid, req1_ready, req1_mode, req1_addr, req1_count, req1_done, req1_err  same as requester 0
- m_mode  out  2  to master c_m00_mode
- m_addra  out  ADDR_WIDTH  to master c_m00_off_mem_addra
- m_addrb  out  ADDR_WIDTH  to master c_m00_off_mem_addrb
- m_txn_en  out  1  to master m00_axi_txn_en
- m_inst_done  in  1  from master m00_axi_inst_done (level)
- busy  out  1  high in any state other than IDLE
- grant_id  out  1  requester currently owning the master; valid while busy

Behaviour:
- Reset (synchronous, priority over everything):
  - All outputs go to 0, state goes to IDLE, rr_ptr goes to 0.
  - Reset mid-instruction drops m_txn_en on the next edge.
  - No done pulse is issued for the aborted command.
- States: IDLE, ISSUE, WAIT_DONE, WAIT_CLR, FINISH.
- IDLE:
  - Service order when both requesters are valid: start with rr_ptr and alternate.
  - When only one is valid, grant it regardless of rr_ptr.
  - On grant: pulse reqN_ready for one cycle; latch mode/addr/count into cur_*; set grant_id; flip rr_ptr to the other requester.
  - If mode is not in {1,2}: set err and go to FINISH.
  - If count == 0: go to FINISH with err = 0.
  - Otherwise go to ISSUE.
- ISSUE:
  - Only entered with m_inst_done == 0.
  - Drive m_mode = cur_mode.
  - LOAD_DATA: drive m_addrb = cur_addr, m_addra = 0.
  - WRITE_DATA: drive m_addra = cur_addr, m_addrb = 0.
  - Assert m_txn_en and go to WAIT_DONE. Mode and address are stable on or before the cycle m_txn_en rises.
- WAIT_DONE:
  - Hold m_txn_en = 1 and the mode/address.
  - When m_inst_done == 1: deassert m_txn_en on the next edge, go to WAIT_CLR, cur_count -= 1, cur_addr += ADDR_STEP (wraps modulo 2^ADDR_WIDTH).
- WAIT_CLR:
  - Wait for m_inst_done == 0.
  - If cur_count == 0, go to FINISH; otherwise go to ISSUE.
  - Minimum 2 cycles between consecutive m_txn_en rises.
- Timeout:
  - A counter clears on entry to WAIT_DONE and to WAIT_CLR.
  - If it reaches TIMEOUT_CYCLES: drop m_txn_en, set err, go to FINISH.
  - After a timeout, do not grant again until m_inst_done == 0.
- FINISH:
  - Pulse reqN_done (N = grant_id) for one cycle, with reqN_err.
  - Drive m_mode = 0 (IDLE), then go to IDLE.
  - The done pulse is never produced in the same cycle as ready.
- No pre-emption: a command runs to completion before arbitration happens again.
- Requester inputs are sampled only in the grant cycle; they may change afterwards.
- Latency:
  - valid to ready: 1 cycle when IDLE.
  - ready to first m_txn_en: 1 cycle.
  - Last inst_done fall to done: 2 cycles.

Decomposition:
- Shared package axi_sched_pkg:
  - mode constants MODE_IDLE = 2'b00, MODE_LOAD = 2'b01, MODE_WRITE = 2'b10
  - state enum
  - default ADDR_STEP
- One sub-module, rr_arbiter2: 2-way round-robin with the pointer update on grant.
- The sequencing FSM and counters stay in the top.

Test Plan:
- Single load: req0 {mode 1, addr 0x00, count 4}, slave with 5-cycle inst_done:
  - 4 m_txn_en pulses with m_addrb = 0x00, 0x04, 0x08, 0x0C and m_addra = 0.
  - req0_done once with err = 0; busy low afterwards.
- Contention: req0 {1, 0x40, 2} and req1 {2, 0x80, 2} valid in the same cycle after reset:
  - req0 served first (m_addrb 0x40, 0x44).
  - Then req1 (m_addra 0x80, 0x84).
  - A second simultaneous pair is served req1 first.
- Illegal/empty commands:
  - req1 {mode 3, count 5}: req1_done with err = 1, zero m_txn_en pulses.
  - req0 {mode 1, count 0}: done with err = 0, zero pulses.
- Wrap: req0 {1, 0xFFFFFFFC, 2}: m_addrb = 0xFFFFFFFC then 0x00000000.
- Timeout: slave never raises inst_done, TIMEOUT_CYCLES = 16:
  - m_txn_en drops at cycle 16 of WAIT_DONE.
  - req0_done with err = 1.
- Reset mid-operation: assert reset during WAIT_DONE of the 2nd of 4 instructions:
  - Next cycle m_txn_en = 0, busy = 0, no done pulse.
  - A fresh command afterwards starts from its own base address.

Source files
------------

// File: rtl/axi_sched_pkg.sv
// Shared definitions for the AXI transaction scheduler.
//   - master mode encodings driven on m_mode / accepted on reqN_mode
//   - sequencing FSM state encoding
//   - default per-instruction address increment
//   - mode_legal(): true for the modes that produce bus instructions
package axi_sched_pkg;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;

    // One instruction moves AXI_TRANSACTIONS_NUM (4) words' worth of address.
    localparam int DEFAULT_ADDR_STEP = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_WAIT_CLR  = 3'd3,
        ST_FINISH    = 3'd4
    } state_t;

    function automatic logic mode_legal(input logic [1:0] mode);
        return (mode == MODE_LOAD) || (mode == MODE_WRITE);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset (pointer -> requester 0)
//   req[1:0]   : request lines, bit N = requester N
//   enable     : arbitration allowed this cycle
//   gnt_valid  : a grant is issued this cycle (combinational)
//   gnt_id     : granted requester (combinational, meaningful with gnt_valid)
// When both request, rr_ptr wins; a lone requester wins regardless of rr_ptr.
// Every grant moves the pointer to the requester that did not win.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic rr_ptr;

    assign gnt_valid = enable && (req != 2'b00);

    always_comb begin
        gnt_id = req[1];
        if (req == 2'b11) begin
            gnt_id = rr_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (gnt_valid) begin
            rr_ptr <= ~gnt_id;
        end
    end

endmodule

// File: rtl/axi_txn_scheduler.sv
// Sequences the AXI4-Lite master instruction interface for two requesters
// (0 = activation/weight loader, 1 = result writer). Each accepted block
// command {mode, base address, count} is expanded into count txn_en/inst_done
// handshakes with the address stepping by ADDR_STEP, then a done pulse (with
// err) is returned to the owning requester.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   reqN_valid/ready           command handshake, N = 0,1
//   reqN_mode/addr/count       command fields, sampled only in the grant cycle
//   reqN_done/err              one-cycle completion pulse, err qualifies done
//   m_mode, m_addra, m_addrb   instruction fields to the AXI master
//   m_txn_en, m_inst_done      per-instruction handshake with the AXI master
//   busy                       FSM not in IDLE
//   grant_id                   owning requester, valid while busy
//   dbg_state                  current FSM state encoding
//
// Command handshake: a requester holds reqN_valid with stable fields until it
// sees reqN_ready high for one cycle; ready is registered, so it appears the
// cycle after the scheduler sampled valid in IDLE, and the fields captured are
// the ones present on that sampling edge. The requester drops valid (or moves
// to its next command) in the ready cycle.
module axi_txn_scheduler
    import axi_sched_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int CNT_WIDTH      = 8,
    parameter int ADDR_STEP      = DEFAULT_ADDR_STEP,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [1:0]            req0_mode,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [CNT_WIDTH-1:0]  req0_count,
    output logic                  req0_done,
    output logic                  req0_err,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [1:0]            req1_mode,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [CNT_WIDTH-1:0]  req1_count,
    output logic                  req1_done,
    output logic                  req1_err,
    output logic [1:0]            m_mode,
    output logic [ADDR_WIDTH-1:0] m_addra,
    output logic [ADDR_WIDTH-1:0] m_addrb,
    output logic                  m_txn_en,
    input  logic                  m_inst_done,
    output logic                  busy,
    output logic                  grant_id,
    output logic [2:0]            dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    state_t                state;
    logic [1:0]            cur_mode;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [CNT_WIDTH-1:0]  cur_count;
    logic                  cur_err;
    logic [TW-1:0]         tcnt;
    logic                  timeout_hit;

    logic                  gnt_valid;
    logic                  gnt_id;
    logic [1:0]            sel_mode;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [CNT_WIDTH-1:0]  sel_count;

    // Granting only while inst_done is low guarantees ISSUE is entered with
    // the master quiet, including after a timeout left inst_done stuck high.
    rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       ({req1_valid, req0_valid}),
        .enable    ((state == ST_IDLE) && !m_inst_done),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign sel_mode  = gnt_id ? req1_mode  : req0_mode;
    assign sel_addr  = gnt_id ? req1_addr  : req0_addr;
    assign sel_count = gnt_id ? req1_count : req0_count;

    // tcnt counts cycles already spent in WAIT_DONE / WAIT_CLR; the last
    // permitted cycle is the one where it reads TIMEOUT_CYCLES-1.
    assign timeout_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cur_mode   <= MODE_IDLE;
            cur_addr   <= '0;
            cur_count  <= '0;
            cur_err    <= 1'b0;
            tcnt       <= '0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_err   <= 1'b0;
            req1_err   <= 1'b0;
            m_mode     <= MODE_IDLE;
            m_addra    <= '0;
            m_addrb    <= '0;
            m_txn_en   <= 1'b0;
            grant_id   <= 1'b0;
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_err   <= 1'b0;
            req1_err   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        grant_id  <= gnt_id;
                        if (gnt_id) begin
                            req1_ready <= 1'b1;
                        end else begin
                            req0_ready <= 1'b1;
                        end
                        cur_mode  <= sel_mode;
                        cur_addr  <= sel_addr;
                        cur_count <= sel_count;
                        if (!mode_legal(sel_mode)) begin
                            cur_err <= 1'b1;
                            state   <= ST_FINISH;
                        end else if (sel_count == '0) begin
                            cur_err <= 1'b0;
                            state   <= ST_FINISH;
                        end else begin
                            cur_err <= 1'b0;
                            state   <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    m_mode   <= cur_mode;
                    m_addra  <= (cur_mode == MODE_WRITE) ? cur_addr : '0;
                    m_addrb  <= (cur_mode == MODE_LOAD)  ? cur_addr : '0;
                    m_txn_en <= 1'b1;
                    tcnt     <= '0;
                    state    <= ST_WAIT_DONE;
                end

                ST_WAIT_DONE: begin
                    if (m_inst_done) begin
                        m_txn_en  <= 1'b0;
                        cur_count <= cur_count - CNT_WIDTH'(1);
                        cur_addr  <= cur_addr + ADDR_WIDTH'(ADDR_STEP);
                        tcnt      <= '0;
                        state     <= ST_WAIT_CLR;
                    end else if (timeout_hit) begin
                        m_txn_en <= 1'b0;
                        cur_err  <= 1'b1;
                        state    <= ST_FINISH;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                ST_WAIT_CLR: begin
                    if (!m_inst_done) begin
                        state <= (cur_count == '0) ? ST_FINISH : ST_ISSUE;
                    end else if (timeout_hit) begin
                        cur_err <= 1'b1;
                        state   <= ST_FINISH;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                ST_FINISH: begin
                    // done lands in the cycle after FINISH, so it can never
                    // coincide with the ready pulse of the same command.
                    if (grant_id) begin
                        req1_done <= 1'b1;
                        req1_err  <= cur_err;
                    end else begin
                        req0_done <= 1'b1;
                        req0_err  <= cur_err;
                    end
                    m_mode  <= MODE_IDLE;
                    m_addra <= '0;
                    m_addrb <= '0;
                    state   <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_txn_scheduler.sv
// Directed + randomized bench for axi_txn_scheduler with a reference model
// built from the command rules: each legal command with count N produces N
// instruction beats at base + i*STEP; illegal modes and empty commands produce
// only a done; arbitration order is predicted from a round-robin pointer.
module tb_axi_txn_scheduler;

    localparam int AW   = 32;
    localparam int CW   = 8;
    localparam int STEP = 4;
    localparam int TMO  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready, req0_done, req0_err;
    logic [1:0]    req0_mode;
    logic [AW-1:0] req0_addr;
    logic [CW-1:0] req0_count;
    logic          req1_valid, req1_ready, req1_done, req1_err;
    logic [1:0]    req1_mode;
    logic [AW-1:0] req1_addr;
    logic [CW-1:0] req1_count;
    logic [1:0]    m_mode;
    logic [AW-1:0] m_addra, m_addrb;
    logic          m_txn_en, m_inst_done;
    logic          busy, grant_id;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    axi_txn_scheduler #(
        .ADDR_WIDTH     (AW),
        .CNT_WIDTH      (CW),
        .ADDR_STEP      (STEP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_mode   (req0_mode),
        .req0_addr   (req0_addr),
        .req0_count  (req0_count),
        .req0_done   (req0_done),
        .req0_err    (req0_err),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_mode   (req1_mode),
        .req1_addr   (req1_addr),
        .req1_count  (req1_count),
        .req1_done   (req1_done),
        .req1_err    (req1_err),
        .m_mode      (m_mode),
        .m_addra     (m_addra),
        .m_addrb     (m_addrb),
        .m_txn_en    (m_txn_en),
        .m_inst_done (m_inst_done),
        .busy        (busy),
        .grant_id    (grant_id),
        .dbg_state   (dbg_state)
    );

    // Scoreboard: beats are {m_mode, m_addra, m_addrb}; dones are {id, err}.
    logic [65:0] exp_q[$];
    logic [1:0]  done_q[$];
    int          total = 0;
    int          bad = 0;
    int          rise_cnt = 0;
    int          slave_lat = 5;
    bit          model_ptr = 1'b0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave: raises inst_done slave_lat cycles into a txn_en, drops it once
    // txn_en falls.
    initial begin
        int lat_cnt;
        lat_cnt = 0;
        m_inst_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (m_txn_en && !m_inst_done) begin
                lat_cnt++;
                if (lat_cnt >= slave_lat) m_inst_done = 1'b1;
            end else if (!m_txn_en) begin
                m_inst_done = 1'b0;
                lat_cnt = 0;
            end
        end
    end

    // Monitor: every txn_en rise and every done pulse is matched in order.
    initial begin
        logic prev_txn;
        prev_txn = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && m_txn_en && !prev_txn) begin
                rise_cnt++;
                check("beat_expected", 80'(exp_q.size() != 0), 80'd1);
                if (exp_q.size() != 0)
                    check("beat_fields", 80'({m_mode, m_addra, m_addrb}), 80'(exp_q.pop_front()));
            end
            prev_txn = m_txn_en;
            if (req0_done || req1_done) begin
                check("done_one_hot", 80'(req0_done & req1_done), 80'd0);
                check("done_vs_ready", 80'(req0_ready | req1_ready), 80'd0);
                check("done_expected", 80'(done_q.size() != 0), 80'd1);
                if (done_q.size() != 0)
                    check("done_id_err", 80'({req1_done, req1_done ? req1_err : req0_err}),
                          80'(done_q.pop_front()));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit legal(input logic [1:0] mode);
        return (mode == 2'd1) || (mode == 2'd2);
    endfunction

    task automatic push_cmd(input bit id, input logic [1:0] mode, input logic [31:0] addr,
                            input logic [7:0] count);
        logic [31:0] a;
        if (legal(mode)) begin
            for (int i = 0; i < int'(count); i++) begin
                a = addr + 32'(i * STEP);
                if (mode == 2'd1) exp_q.push_back({2'd1, 32'd0, a});
                else              exp_q.push_back({2'd2, a, 32'd0});
            end
        end
        done_q.push_back({id, !legal(mode)});
    endtask

    task automatic drive(input bit id, input logic [1:0] mode, input logic [31:0] addr,
                         input logic [7:0] count, input logic valid);
        if (id) begin
            req1_valid = valid; req1_mode = mode; req1_addr = addr; req1_count = count;
        end else begin
            req0_valid = valid; req0_mode = mode; req0_addr = addr; req0_count = count;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (k < 400 && (done_q.size() != 0 || exp_q.size() != 0 || busy)) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_idle", 80'({done_q.size() != 0, exp_q.size() != 0, busy}), 80'd0);
    endtask

    // Single command into an idle scheduler; fields are scrambled after the
    // grant to show they are sampled only once.
    task automatic send(input bit id, input logic [1:0] mode, input logic [31:0] addr,
                        input logic [7:0] count);
        int r0;
        push_cmd(id, mode, addr, count);
        model_ptr = !id;
        r0 = rise_cnt;
        drive(id, mode, addr, count, 1'b1);
        @(posedge clk);
        #1;
        check("ready_latency", 80'(id ? req1_ready : req0_ready), 80'd1);
        check("grant_id", 80'(grant_id), 80'(id));
        drive(id, 2'($urandom), $urandom, 8'($urandom), 1'b0);
        @(posedge clk);
        #1;
        if (legal(mode) && count != 0) check("txn_latency", 80'(m_txn_en), 80'd1);
        drain();
        if (!legal(mode) || count == 0) check("no_beats", 80'(rise_cnt - r0), 80'd0);
    endtask

    task automatic send_pair(input logic [1:0] m0, input logic [31:0] a0, input logic [7:0] c0,
                             input logic [1:0] m1, input logic [31:0] a1, input logic [7:0] c1);
        int first;
        int k;
        bit exp_first;
        exp_first = model_ptr;
        if (exp_first) begin
            push_cmd(1'b1, m1, a1, c1);
            push_cmd(1'b0, m0, a0, c0);
        end else begin
            push_cmd(1'b0, m0, a0, c0);
            push_cmd(1'b1, m1, a1, c1);
        end
        // First grant points away from the winner; the lone second grant
        // points back again.
        model_ptr = !exp_first;
        model_ptr = exp_first;
        drive(1'b0, m0, a0, c0, 1'b1);
        drive(1'b1, m1, a1, c1, 1'b1);
        first = -1;
        k = 0;
        while (k < 600 && (req0_valid || req1_valid)) begin
            @(posedge clk);
            #1;
            k++;
            if (req0_ready) begin
                if (first < 0) first = 0;
                drive(1'b0, 2'd0, 32'd0, 8'd0, 1'b0);
            end
            if (req1_ready) begin
                if (first < 0) first = 1;
                drive(1'b1, 2'd0, 32'd0, 8'd0, 1'b0);
            end
        end
        check("pair_both_granted", 80'({req0_valid, req1_valid}), 80'd0);
        check("pair_order", 80'(first), 80'(exp_first));
        drain();
    endtask

    initial begin
        int r0;
        int cnt;
        int k;
        reset = 1'b1;
        drive(1'b0, 2'd0, 32'd0, 8'd0, 1'b0);
        drive(1'b1, 2'd0, 32'd0, 8'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", 80'({req0_ready, req0_done, req0_err, req1_ready, req1_done,
                                 req1_err, m_mode, m_txn_en, busy, grant_id}), 80'd0);
        check("reset_addr", 80'({m_addra, m_addrb}), 80'd0);
        check("reset_state", 80'(dbg_state), 80'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Contention right after reset: requester 0 first.
        slave_lat = 3;
        send_pair(2'd1, 32'h40, 8'd2, 2'd2, 32'h80, 8'd2);

        // Single load with a 5-cycle slave; moves the pointer to requester 1.
        slave_lat = 5;
        send(1'b0, 2'd1, 32'h00, 8'd4);

        // Second simultaneous pair: requester 1 first.
        slave_lat = 2;
        send_pair(2'd1, 32'h500, 8'd1, 2'd2, 32'h600, 8'd2);

        // Illegal mode and empty command.
        send(1'b1, 2'd3, 32'h700, 8'd5);
        send(1'b0, 2'd1, 32'h10, 8'd0);

        // Address wrap.
        send(1'b0, 2'd1, 32'hFFFF_FFFC, 8'd2);

        // Timeout: the slave never answers.
        slave_lat = 1000;
        exp_q.push_back({2'd1, 32'd0, 32'h100});
        done_q.push_back(2'b01);
        model_ptr = 1'b1;
        drive(1'b0, 2'd1, 32'h100, 8'd3, 1'b1);
        @(posedge clk);
        #1;
        check("tmo_ready", 80'(req0_ready), 80'd1);
        drive(1'b0, 2'd0, 32'd0, 8'd0, 1'b0);
        @(posedge clk);
        #1;
        cnt = 0;
        while (m_txn_en && cnt < 100) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        check("timeout_len", 80'(cnt), 80'(TMO));
        drain();

        // Reset during WAIT_DONE of the 2nd of 4 instructions.
        slave_lat = 5;
        exp_q.push_back({2'd1, 32'd0, 32'h200});
        exp_q.push_back({2'd1, 32'd0, 32'h204});
        r0 = rise_cnt;
        drive(1'b0, 2'd1, 32'h200, 8'd4, 1'b1);
        @(posedge clk);
        #1;
        check("rst_ready", 80'(req0_ready), 80'd1);
        drive(1'b0, 2'd0, 32'd0, 8'd0, 1'b0);
        k = 0;
        while (k < 200 && rise_cnt < r0 + 2) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("rst_second_beat", 80'(rise_cnt - r0), 80'd2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_txn_drop", 80'(m_txn_en), 80'd0);
        check("rst_busy", 80'(busy), 80'd0);
        reset = 1'b0;
        model_ptr = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("rst_no_leftover", 80'(exp_q.size()), 80'd0);

        // Fresh command after reset starts from its own base.
        send(1'b1, 2'd2, 32'h300, 8'd2);

        // Randomized commands, single and paired.
        for (int it = 0; it < 12; it++) begin
            slave_lat = $urandom_range(1, 6);
            if ($urandom_range(0, 1) == 1) begin
                send_pair(2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 4)),
                          2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 4)));
            end else begin
                send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     $urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 4)));
            end
        end

        check("queues_empty", 80'({exp_q.size() != 0, done_q.size() != 0}), 80'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
